multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Moore-style control finite state machine for the multicycle CPU. It sequences the shared datapath registers (PC, IR, memory data register, A/B, ALUOut) and the single unified memory port, one instruction at a time. It decodes the opcode latched in IR and drives every datapath enable and mux select. It also stalls on a memory ready handshake, halts on illegal opcodes and counts retired instructions.

## Interface

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- clock  input  1  system clock; all state changes on posedge
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clock
- Op  input  6  opcode field IR[31:26]
- MemReady  input  1  memory handshake; access completes in a cycle where it is 1
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero (beq)
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  IR load
- MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR
- RegDst  output  1  destination: 0=rt, 1=rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0=PC, 1=A
- ALUSrcB  output  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- ALUOp  output  2  0=add, 1=sub, 2=funct-decoded
- PCSource  output  2  0=ALU result, 1=ALUOut, 2=jump target
- State  output  4  current state encoding (debug)
- Halted  output  1  1 while in HALT
- InstrCount  output  COUNT_WIDTH  retired-instruction count

## Operation

- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010; any other value is illegal.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12. Codes 13-15 are unreachable and go to FETCH.
- Every output defaults to 0. Each state asserts only the signals listed for it:
  - FETCH: MemRead=1, ALUSrcB=1. When MemReady=1, also IRWrite=1 and PCWrite=1.
  - DECODE: ALUSrcB=3.
  - MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=2.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUOp=2.
  - RWB: RegWrite=1, RegDst=1.
  - ADDIWB: RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=1, PCWriteCond=1, PCSource=1.
  - JUMP: PCWrite=1, PCSource=2.
  - HALT: Halted=1.
- Transitions:
  - FETCH→DECODE when MemReady=1; otherwise hold.
  - DECODE→ by Op: LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX, illegal→HALT.
  - MEMADR→MEMRD on LW, →MEMWR on SW.
  - MEMRD→MEMWB when MemReady=1; otherwise hold.
  - MEMWR→FETCH when MemReady=1; otherwise hold.
  - EXEC→RWB; ADDIEX→ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH, JUMP→FETCH.
  - HALT holds until reset.
- Retirement: InstrCount increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, ADDIWB, BRANCH or JUMP. It wraps from all-ones to 0. A not-taken BEQ still counts.
- Op is sampled only in DECODE and MEMADR; it is ignored in all other states.

## Timing

- Reset: a posedge with reset_n=0 forces State=FETCH and InstrCount=0. This happens from any state, including mid-stall, HALT and mid-write. After reset all outputs follow the FETCH decode; Halted=0.
- Outputs are decoded from State, except that IRWrite and PCWrite in FETCH are also gated by MemReady.
- Instruction latency with MemReady tied to 1:
  - BEQ and J: 3 cycles.
  - R and ADDI: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. During the wait, MemRead, MemWrite and IorD stay stable, and no register enable pulses.
- MemReady has no effect in any other state.

## Test plan

- Reset with MemReady=1, Op=000000: State sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 only in the RWB cycle. InstrCount reads 1 after the return to FETCH.
- LW (100011) with MemReady low for 3 cycles in MEMRD: State sequence 0,1,2,3,3,3,3,4,0. MemRead=1 and IorD=1 are held all 4 MEMRD cycles. Total latency is 8 cycles.
- SW then BEQ then J with MemReady=1: states 0,1,2,5 / 0,1,8 / 0,1,9. PCWriteCond=1 with PCSource=1 in BRANCH; PCWrite=1 with PCSource=2 in JUMP. InstrCount=3.
- FETCH with MemReady=0 for 2 cycles: IRWrite=0 and PCWrite=0 during the wait. Both are 1 in the single cycle where MemReady=1, then State=1.
- Illegal Op=111111 in DECODE: State=12 and Halted=1, held for 10+ cycles, InstrCount unchanged. Then reset_n=0 for one posedge: State=0, Halted=0, InstrCount=0.
- Reset asserted in MEMWR while MemReady=0: the next State is 0 and MemWrite drops to 0. Preload InstrCount to 2^COUNT_WIDTH−1 (COUNT_WIDTH=4 build, value 15); one retirement then gives 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle CPU: sequences the shared datapath and
// unified memory port, stalls on MemReady, halts on illegal opcodes, counts retirements.
module multicycle_control_unit #(
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [5:0]             Op,
   input  logic                   MemReady,
   output logic                   PCWrite,
   output logic                   PCWriteCond,
   output logic                   IorD,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic                   MemtoReg,
   output logic                   RegDst,
   output logic                   RegWrite,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [1:0]             ALUOp,
   output logic [1:0]             PCSource,
   output logic [3:0]             State,
   output logic                   Halted,
   output logic [COUNT_WIDTH-1:0] InstrCount
);

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 4;

   localparam logic [OP_W-1:0] OP_R    = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
   localparam logic [OP_W-1:0] OP_J    = 6'b000010;

   localparam logic [1:0] SRCB_B     = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] PCSRC_ALU  = 2'd0;
   localparam logic [1:0] PCSRC_OUT  = 2'd1;
   localparam logic [1:0] PCSRC_JUMP = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11,
      HALT   = 4'd12
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   retire_c;
   logic [COUNT_WIDTH-1:0] count_q;

   // State register; reset is synchronous so it wins from any state, even mid-stall.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Retired-instruction counter, wraps naturally at all-ones.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (retire_c) begin
         count_q <= count_q + COUNT_WIDTH'(1);
      end
   end

   // Next-state logic and the retirement strobe.
   always_comb begin
      state_d  = state_q;
      retire_c = 1'b0;
      case (state_q)
         FETCH: begin
            if (MemReady) state_d = DECODE;
         end
         DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               OP_ADDI:      state_d = ADDIEX;
               default:      state_d = HALT;
            endcase
         end
         MEMADR: begin
            // Only LW/SW reach here; anything else means IR was corrupted.
            case (Op)
               OP_LW:   state_d = MEMRD;
               OP_SW:   state_d = MEMWR;
               default: state_d = HALT;
            endcase
         end
         MEMRD: begin
            if (MemReady) state_d = MEMWB;
         end
         MEMWR: begin
            if (MemReady) begin
               state_d  = FETCH;
               retire_c = 1'b1;
            end
         end
         EXEC:   state_d = RWB;
         ADDIEX: state_d = ADDIWB;
         MEMWB, RWB, ADDIWB, BRANCH, JUMP: begin
            state_d  = FETCH;
            retire_c = 1'b1;
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // Moore output decode; only the FETCH register enables look at MemReady.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUOp       = ALU_ADD;
      PCSource    = PCSRC_ALU;
      Halted      = 1'b0;
      case (state_q)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         DECODE: begin
            ALUSrcB = SRCB_IMMSH;
         end
         MEMADR, ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_FUNCT;
         end
         RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         ADDIWB: begin
            RegWrite = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_OUT;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         HALT: begin
            Halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign State      = state_q;
   assign InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit (COUNT_WIDTH=4 build): expected
// state/control words are queued per driven cycle and compared at the falling edge.
module tb_multicycle_control_unit;

   localparam int unsigned CW = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic          clock;
   logic          reset_n;
   logic [5:0]    Op;
   logic          MemReady;
   logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic          MemtoReg, RegDst, RegWrite, ALUSrcA, Halted;
   logic [1:0]    ALUSrcB, ALUOp, PCSource;
   logic [3:0]    State;
   logic [CW-1:0] InstrCount;

   multicycle_control_unit #(.COUNT_WIDTH(CW)) dut (
      .clock(clock), .reset_n(reset_n), .Op(Op), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .State(State), .Halted(Halted),
      .InstrCount(InstrCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          st;
      logic [16:0] ctrl;
      string       tag;
   } exp_t;

   exp_t          sb_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   logic [CW-1:0] exp_cnt;
   logic [16:0]   ctrl_obs;

   assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                      PCSource, Halted};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference control word for a state, written straight from the state table.
   function automatic logic [16:0] exp_ctrl(input int st, input logic rdy);
      logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, h;
      logic [1:0] sb, ao, ps;
      {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, h} = '0;
      sb = 2'd0; ao = 2'd0; ps = 2'd0;
      case (st)
         0:  begin mr = 1'b1; sb = 2'd1; irw = rdy; pcw = rdy; end
         1:  sb = 2'd3;
         2:  begin sa = 1'b1; sb = 2'd2; end
         3:  begin mr = 1'b1; iord = 1'b1; end
         4:  begin rw = 1'b1; m2r = 1'b1; end
         5:  begin mw = 1'b1; iord = 1'b1; end
         6:  begin sa = 1'b1; ao = 2'd2; end
         7:  begin rw = 1'b1; rd = 1'b1; end
         8:  begin sa = 1'b1; ao = 2'd1; pcwc = 1'b1; ps = 2'd1; end
         9:  begin pcw = 1'b1; ps = 2'd2; end
         10: begin sa = 1'b1; sb = 2'd2; end
         11: rw = 1'b1;
         12: h = 1'b1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, h};
   endfunction

   function automatic logic [5:0] rnd_op();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock: queue expectation, drive inputs, compare at the falling edge.
   task automatic step(input logic [5:0] op, input logic rdy, input int st, input string tag);
      exp_t e;
      exp_t g;
      e.st   = st;
      e.ctrl = exp_ctrl(st, rdy);
      e.tag  = tag;
      sb_q.push_back(e);
      Op       = op;
      MemReady = rdy;
      @(negedge clock);
      g = sb_q.pop_front();
      check({g.tag, "_state"}, 32'(State), 32'(g.st));
      check({g.tag, "_ctrl"}, 32'(ctrl_obs), 32'(g.ctrl));
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      MemReady = rnd_bit();
      Op       = rnd_op();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      exp_cnt = '0;
   endtask

   // Runs one instruction from FETCH, with optional stalls in FETCH and the memory state.
   task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
      check("cnt_at_fetch", 32'(InstrCount), 32'(exp_cnt));
      for (int i = 0; i < fstall; i++) step(rnd_op(), 1'b0, 0, "fetch_wait");
      step(rnd_op(), 1'b1, 0, "fetch");
      step(op, rnd_bit(), 1, "decode");
      case (op)
         OP_LW: begin
            step(op, rnd_bit(), 2, "lw_memadr");
            for (int i = 0; i < mstall; i++) step(rnd_op(), 1'b0, 3, "memrd_wait");
            step(rnd_op(), 1'b1, 3, "memrd");
            step(rnd_op(), rnd_bit(), 4, "memwb");
         end
         OP_SW: begin
            step(op, rnd_bit(), 2, "sw_memadr");
            for (int i = 0; i < mstall; i++) step(rnd_op(), 1'b0, 5, "memwr_wait");
            step(rnd_op(), 1'b1, 5, "memwr");
         end
         OP_R: begin
            step(rnd_op(), rnd_bit(), 6, "exec");
            step(rnd_op(), rnd_bit(), 7, "rwb");
         end
         OP_ADDI: begin
            step(rnd_op(), rnd_bit(), 10, "addiex");
            step(rnd_op(), rnd_bit(), 11, "addiwb");
         end
         OP_BEQ: step(rnd_op(), rnd_bit(), 8, "branch");
         OP_J:   step(rnd_op(), rnd_bit(), 9, "jump");
         default: begin
            for (int i = 0; i < 12; i++) step(rnd_op(), rnd_bit(), 12, "halt");
            check("cnt_halt", 32'(InstrCount), 32'(exp_cnt));
            return;
         end
      endcase
      exp_cnt = exp_cnt + CW'(1);
      check("cnt_retire", 32'(InstrCount), 32'(exp_cnt));
   endtask

   initial begin
      logic [5:0] legal [6];
      legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
      reset_n  = 1'b0;
      MemReady = 1'b1;
      Op       = OP_R;
      exp_cnt  = '0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      check("reset_state", 32'(State), 32'd0);
      check("reset_halted", 32'(Halted), 32'd0);

      run_instr(OP_R, 0, 0);
      run_instr(OP_LW, 0, 3);
      run_instr(OP_SW, 0, 0);
      run_instr(OP_BEQ, 0, 0);
      run_instr(OP_J, 0, 0);
      run_instr(OP_ADDI, 2, 0);
      run_instr(OP_SW, 1, 2);
      run_instr(OP_BAD, 0, 0);

      do_reset();
      check("halt_reset_state", 32'(State), 32'd0);
      check("halt_reset_halted", 32'(Halted), 32'd0);
      check("halt_reset_cnt", 32'(InstrCount), 32'd0);

      // Sixteen retirements in the 4-bit build: 15 then wrap to 0.
      for (int i = 0; i < 15; i++) begin
         run_instr(legal[$urandom_range(0, 5)], $urandom_range(0, 1), $urandom_range(0, 2));
      end
      check("cnt_all_ones", 32'(InstrCount), 32'd15);
      run_instr(OP_BEQ, 0, 0);
      check("cnt_wrap", 32'(InstrCount), 32'd0);

      // Reset while a store is stalled in MEMWR.
      run_instr(OP_J, 0, 0);
      step(rnd_op(), 1'b1, 0, "fetch");
      step(OP_SW, rnd_bit(), 1, "decode");
      step(OP_SW, rnd_bit(), 2, "sw_memadr");
      step(rnd_op(), 1'b0, 5, "memwr_wait");
      reset_n = 1'b0;
      step(rnd_op(), 1'b0, 5, "memwr_in_reset");
      reset_n = 1'b1;
      exp_cnt = '0;
      check("memwr_reset_cnt", 32'(InstrCount), 32'(exp_cnt));
      step(rnd_op(), 1'b0, 0, "post_reset_fetch");
      check("post_reset_memwrite", 32'(MemWrite), 32'd0);
      run_instr(OP_R, 0, 0);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
